// File: rtl/dct_group_scheduler.sv
// dct_group_scheduler: sequences the DCT engine bank over one completed ingester
// buffer. It watches for ingester buffer swaps, holds the engines in reset between
// MCU groups, steps the group fetch base, rotates the output ring slot, and stalls
// when every output slot is still waiting on the quantizer.
module dct_group_scheduler #(
    parameter int NUM_ENGINES  = 5,
    parameter int MCU_GROUPS   = 8,
    parameter int RESET_CYCLES = 3,
    parameter int OUT_SLOTS    = 4,
    localparam int MG_W = (MCU_GROUPS > 1) ? $clog2(MCU_GROUPS) : 1,
    localparam int SL_W = (OUT_SLOTS > 1) ? $clog2(OUT_SLOTS) : 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   ingester_frontbuf,
    input  logic [NUM_ENGINES-1:0] dcts_finished,
    input  logic                   quant_slot_done,
    output logic                   dct_nreset,
    output logic                   dct_read_bank,
    output logic [MG_W-1:0]        mcu_group,
    output logic [SL_W-1:0]        out_slot,
    output logic [SL_W:0]          slots_used,
    output logic                   frame_done,
    output logic                   error
);

    localparam int RC_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [RC_W-1:0] RC_LAST    = RC_W'(RESET_CYCLES - 1);
    localparam logic [MG_W-1:0] GROUP_LAST = MG_W'(MCU_GROUPS - 1);
    localparam logic [SL_W:0]   SLOTS_FULL = (SL_W + 1)'(OUT_SLOTS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET,
        S_ACTIVE,
        S_STALL,
        S_ERR
    } state_t;

    state_t          state_q, state_d;
    logic [RC_W-1:0] rcnt_q, rcnt_d;
    logic [MG_W-1:0] group_q, group_d;
    logic [SL_W-1:0] slot_q, slot_d;
    logic [SL_W:0]   used_q, used_d;
    logic            bank_q, bank_d;
    logic            frame_done_q, frame_done_d;
    logic            error_q, error_d;
    logic            f0_q, f0_d;
    logic            f1_q, f1_d;

    logic            swap;
    logic            group_done;
    logic            q_rel;
    logic            q_under;
    logic [SL_W:0]   used_post;

    // Slot accounting: a finishing group claims a slot, a quantizer pulse frees one;
    // both in the same cycle cancel. Releases with nothing outstanding only flag a fault.
    always_comb begin
        swap       = f0_q ^ f1_q;
        group_done = (state_q == S_ACTIVE) && (&dcts_finished) && !swap;
        q_rel      = quant_slot_done && (used_q != '0) && (state_q != S_ERR);
        q_under    = quant_slot_done && (used_q == '0) && (state_q != S_ERR);
        used_post  = used_q;
        if (group_done && !q_rel && (used_q != SLOTS_FULL)) begin
            used_post = used_q + 1'b1;
        end else if (!group_done && q_rel) begin
            used_post = used_q - 1'b1;
        end
    end

    // Sequencer: next state, group/slot stepping and the swap-overrun fault.
    always_comb begin
        state_d      = state_q;
        rcnt_d       = rcnt_q;
        group_d      = group_q;
        slot_d       = slot_q;
        bank_d       = bank_q;
        frame_done_d = 1'b0;
        f0_d         = ingester_frontbuf;
        f1_d         = f0_q;
        used_d       = used_post;
        case (state_q)
            S_IDLE: begin
                group_d = '0;
                if (swap) begin
                    // f1 still holds the bank the ingester just finished filling
                    bank_d  = f1_q;
                    rcnt_d  = '0;
                    state_d = (used_q < SLOTS_FULL) ? S_RESET : S_STALL;
                end
            end
            S_RESET: begin
                if (swap) begin
                    state_d = S_ERR;
                end else if (rcnt_q == RC_LAST) begin
                    state_d = S_ACTIVE;
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                end
            end
            S_ACTIVE: begin
                if (swap) begin
                    state_d = S_ERR;
                end else if (group_done) begin
                    slot_d = slot_q + 1'b1;
                    if (group_q == GROUP_LAST) begin
                        group_d      = '0;
                        frame_done_d = 1'b1;
                        state_d      = S_IDLE;
                    end else begin
                        group_d = group_q + 1'b1;
                        rcnt_d  = '0;
                        state_d = (used_post < SLOTS_FULL) ? S_RESET : S_STALL;
                    end
                end
            end
            S_STALL: begin
                if (swap) begin
                    state_d = S_ERR;
                end else if (used_q < SLOTS_FULL) begin
                    rcnt_d  = '0;
                    state_d = S_RESET;
                end
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_ERR;
            end
        endcase
        error_d = error_q || q_under || (state_d == S_ERR);
    end

    // State register with synchronous reset; a reset mid-group drops the group.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            rcnt_q       <= '0;
            group_q      <= '0;
            slot_q       <= '0;
            used_q       <= '0;
            bank_q       <= 1'b0;
            frame_done_q <= 1'b0;
            error_q      <= 1'b0;
            f0_q         <= 1'b0;
            f1_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            rcnt_q       <= rcnt_d;
            group_q      <= group_d;
            slot_q       <= slot_d;
            used_q       <= used_d;
            bank_q       <= bank_d;
            frame_done_q <= frame_done_d;
            error_q      <= error_d;
            f0_q         <= f0_d;
            f1_q         <= f1_d;
        end
    end

    assign dct_nreset    = (state_q == S_ACTIVE);
    assign dct_read_bank = bank_q;
    assign mcu_group     = group_q;
    assign out_slot      = slot_q;
    assign slots_used    = used_q;
    assign frame_done    = frame_done_q;
    assign error         = error_q;

endmodule
